// File: rtl/tick_sched_pkg.sv
// Shared types and constants for the tick scheduler and its channels.
package tick_sched_pkg;

  // Config-port sequencer states.
  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_APPLY = 2'd2
  } sched_state_e;

  localparam int DIV_W_DEFAULT = 16;

  // Standard ratios: 8 kHz sample tick from 61.44 MHz, and a 30-sample frame tick.
  localparam int DIV_8K = 7680;
  localparam int DIV_30 = 30;

  // Channel index width; never narrower than one bit.
  function automatic int ch_index_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/tick_chan.sv
// One tick channel: active/shadow ratio, wrap counter and registered tick strobe.
module tick_chan
  import tick_sched_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             apply,
  input  logic             apply_en,
  input  logic [DIV_W-1:0] apply_div,
  input  logic             sync_start,
  output logic             tick,
  output logic             tick_next,
  output logic             active
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             tick_q, tick_d;

  // Next state: free-running wrap first, then config write, then sync restart on top.
  always_comb begin
    div_d    = div_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    en_d     = en_q;
    tick_d   = 1'b0;

    if (en_q) begin
      if (cnt_q == div_q - 1'b1) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        // A pending ratio only takes over at a period boundary.
        if (pend_q) begin
          div_d  = shadow_q;
          pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (apply) begin
      if (!apply_en) begin
        en_d   = 1'b0;
        cnt_d  = '0;
        pend_d = 1'b0;
        tick_d = 1'b0;
      end else if (!en_q) begin
        div_d = apply_div;
        cnt_d = '0;
        en_d  = 1'b1;
      end else begin
        shadow_d = apply_div;
        pend_d   = 1'b1;
      end
    end

    // Sync sees the post-config state so a same-edge config restarts aligned.
    if (sync_start && en_d) begin
      cnt_d  = '0;
      tick_d = 1'b0;
      if (pend_d) begin
        div_d  = shadow_d;
        pend_d = 1'b0;
      end
    end
  end

  // Channel state registers; reset drops any tick immediately.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      div_q    <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      tick_q   <= tick_d;
    end
  end

  assign tick      = tick_q;
  assign tick_next = tick_d;
  assign active    = en_q;

endmodule

// File: rtl/tick_scheduler.sv
// Top: config handshake sequencer, request validation, channel array and ch0 tick counter.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = DIV_W_DEFAULT,
  parameter int CH_W   = ch_index_width(NUM_CH)
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_en,
  output logic              cfg_err,
  input  logic              sync_start,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] ch_active,
  output logic [7:0]        wrap_cnt
);

  sched_state_e     state_q, state_d;
  logic [CH_W-1:0]  lat_ch_q, lat_ch_d;
  logic [DIV_W-1:0] lat_div_q, lat_div_d;
  logic             lat_en_q, lat_en_d;
  logic             lat_err_q, lat_err_d;
  logic [7:0]       wrap_cnt_q, wrap_cnt_d;

  logic             cfg_invalid;
  logic             apply_fire;
  logic [NUM_CH-1:0] tick_next_w;

  assign cfg_invalid = (32'(cfg_ch) >= 32'(NUM_CH)) || (cfg_en && (cfg_div == '0));

  // Sequencer: accept in IDLE, spend exactly one cycle in APPLY, then back to IDLE.
  always_comb begin
    state_d   = state_q;
    lat_ch_d  = lat_ch_q;
    lat_div_d = lat_div_q;
    lat_en_d  = lat_en_q;
    lat_err_d = lat_err_q;
    case (state_q)
      ST_INIT:  state_d = ST_IDLE;
      ST_IDLE: begin
        if (cfg_valid) begin
          state_d   = ST_APPLY;
          lat_ch_d  = cfg_ch;
          lat_div_d = cfg_div;
          lat_en_d  = cfg_en;
          lat_err_d = cfg_invalid;
        end
      end
      ST_APPLY: state_d = ST_IDLE;
      default:  state_d = ST_INIT;
    endcase
  end

  // Sequencer and config latch registers.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_INIT;
      lat_ch_q  <= '0;
      lat_div_q <= '0;
      lat_en_q  <= 1'b0;
      lat_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_ch_q  <= lat_ch_d;
      lat_div_q <= lat_div_d;
      lat_en_q  <= lat_en_d;
      lat_err_q <= lat_err_d;
    end
  end

  assign cfg_ready  = (state_q == ST_IDLE);
  assign apply_fire = (state_q == ST_APPLY) && !lat_err_q;
  assign cfg_err    = (state_q == ST_APPLY) && lat_err_q;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    tick_chan #(
      .DIV_W(DIV_W)
    ) u_chan (
      .sys_clk    (sys_clk),
      .reset      (reset),
      .apply      (apply_fire && (lat_ch_q == CH_W'(gi))),
      .apply_en   (lat_en_q),
      .apply_div  (lat_div_q),
      .sync_start (sync_start),
      .tick       (tick[gi]),
      .tick_next  (tick_next_w[gi]),
      .active     (ch_active[gi])
    );
  end

  // Only channel 0's next-tick feeds the counter; the rest are folded here on purpose.
  logic unused_tick_next;
  assign unused_tick_next = ^tick_next_w;

  // Count ch0 ticks in step with the tick register; sync restarts the count.
  always_comb begin
    wrap_cnt_d = wrap_cnt_q + {7'd0, tick_next_w[0]};
    if (sync_start) wrap_cnt_d = '0;
  end

  // Channel-0 tick counter register.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) wrap_cnt_q <= '0;
    else        wrap_cnt_q <= wrap_cnt_d;
  end

  assign wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: event-time model compared every cycle plus directed literal checks.
// Five channels are used so that a 3-bit channel index can express out-of-range requests.
module tb_tick_scheduler;
  import tick_sched_pkg::*;

  localparam int NCH = 5;

  logic           sys_clk = 1'b0;
  logic           reset = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [2:0]     cfg_ch = '0;
  logic [15:0]    cfg_div = '0;
  logic           cfg_en = 1'b0;
  logic           cfg_err;
  logic           sync_start = 1'b0;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] ch_active;
  logic [7:0]     wrap_cnt;

  int n_cmp = 0;
  int n_err = 0;

  tick_scheduler #(.NUM_CH(NCH), .DIV_W(16)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .cfg_en     (cfg_en),
    .cfg_err    (cfg_err),
    .sync_start (sync_start),
    .tick       (tick),
    .ch_active  (ch_active),
    .wrap_cnt   (wrap_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // Model: each enabled channel knows the edge number of its next tick.
  typedef struct packed {
    logic [31:0]           cyc;
    logic [NCH-1:0]        en;
    logic [NCH-1:0]        pend;
    logic [NCH-1:0]        tick;
    logic [NCH-1:0][15:0]  per;
    logic [NCH-1:0][15:0]  shadow;
    logic [NCH-1:0][31:0]  due;
    logic [7:0]            wrap;
    logic                  ready;
    logic                  apply;
    logic                  lat_en;
    logic                  lat_err;
    logic [2:0]            lat_ch;
    logic [15:0]           lat_div;
  } model_t;

  model_t m;

  function automatic model_t model_next(model_t cur, logic v, logic [2:0] ch,
                                        logic [15:0] div, logic en, logic sync);
    model_t n = cur;
    logic [31:0] t = cur.cyc + 1;
    int c;
    n.cyc = t;
    for (int i = 0; i < NCH; i++) begin
      n.tick[i] = cur.en[i] && (cur.due[i] == t);
      if (n.tick[i]) begin
        if (cur.pend[i]) begin
          n.per[i]  = cur.shadow[i];
          n.pend[i] = 1'b0;
        end
        n.due[i] = t + 32'(n.per[i]);
      end
    end
    if (cur.apply) begin
      n.apply = 1'b0;
      n.ready = 1'b1;
      if (!cur.lat_err) begin
        c = int'(cur.lat_ch);
        if (!cur.lat_en) begin
          n.en[c] = 1'b0; n.pend[c] = 1'b0; n.tick[c] = 1'b0;
        end else if (!cur.en[c]) begin
          n.en[c] = 1'b1; n.per[c] = cur.lat_div; n.due[c] = t + 32'(cur.lat_div);
        end else begin
          n.shadow[c] = cur.lat_div; n.pend[c] = 1'b1;
        end
      end
    end else if (!cur.ready) begin
      n.ready = 1'b1;
    end else if (v) begin
      n.ready   = 1'b0;
      n.apply   = 1'b1;
      n.lat_ch  = ch;
      n.lat_div = div;
      n.lat_en  = en;
      n.lat_err = (int'(ch) >= NCH) || (en && (div == 16'd0));
    end
    if (sync) begin
      for (int i = 0; i < NCH; i++) begin
        if (n.en[i]) begin
          n.tick[i] = 1'b0;
          if (n.pend[i]) begin
            n.per[i]  = n.shadow[i];
            n.pend[i] = 1'b0;
          end
          n.due[i] = t + 32'(n.per[i]);
        end
      end
      n.wrap = 8'd0;
    end else begin
      n.wrap = cur.wrap + {7'd0, n.tick[0]};
    end
    return n;
  endfunction

  always @(posedge sys_clk or negedge reset) begin
    if (!reset) m <= '0;
    else        m <= model_next(m, cfg_valid, cfg_ch, cfg_div, cfg_en, sync_start);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: DUT outputs against the model.
  always @(negedge sys_clk) begin
    check("tick", 32'(tick), 32'(m.tick));
    check("ch_active", 32'(ch_active), 32'(m.en));
    check("wrap_cnt", 32'(wrap_cnt), 32'(m.wrap));
    check("cfg_ready", 32'(cfg_ready), 32'(m.ready));
    check("cfg_err", 32'(cfg_err), 32'(m.apply && m.lat_err));
  end

  // Called at a negedge; returns at the negedge inside the APPLY cycle.
  task automatic do_cfg(input logic [2:0] ch, input logic [15:0] div, input logic en);
    int guard = 0;
    cfg_valid = 1'b1; cfg_ch = ch; cfg_div = div; cfg_en = en;
    while (cfg_ready !== 1'b1 && guard < 20) begin
      @(negedge sys_clk);
      guard++;
    end
    if (cfg_ready !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL cfg_timeout: cfg_ready stayed %b, required 1", cfg_ready);
    end
    @(negedge sys_clk);
    cfg_valid = 1'b0;
    $display("cfg ch=%0d div=%0d en=%0b err=%0b at %0t", ch, div, en, cfg_err, $time);
  endtask

  // Advance negedges until tick[ch] is seen; n is the number of negedges advanced.
  task automatic wait_tick(input int ch, output int n);
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (tick[ch] !== 1'b1 && n < 100);
    if (tick[ch] !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL tick_timeout ch%0d: no tick in %0d cycles, required one", ch, n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset and INIT
    repeat (3) @(negedge sys_clk);
    check("rst_ready", 32'(cfg_ready), 32'd0);
    check("rst_active", 32'(ch_active), 32'd0);
    reset = 1'b1;
    @(negedge sys_clk);
    check("init_ready", 32'(cfg_ready), 32'd1);

    // ch0 div=4: first tick four edges after the APPLY edge, then every 4
    do_cfg(3'd0, 16'd4, 1'b1);
    check("apply_ready_low", 32'(cfg_ready), 32'd0);
    wait_tick(0, n);
    check("first_tick_lat", 32'(n), 32'd5);
    check("active_ch0", 32'(ch_active), 32'h01);
    wait_tick(0, n);
    check("period4", 32'(n), 32'd4);

    // Ratio 4 -> 6 applied at cnt=1: 4-period completes, then 6s
    do_cfg(3'd0, 16'd6, 1'b1);
    wait_tick(0, n);
    check("ratio_tail", 32'(n + 1), 32'd4);
    wait_tick(0, n);
    check("ratio_p6a", 32'(n), 32'd6);
    wait_tick(0, n);
    check("ratio_p6b", 32'(n), 32'd6);

    // ch1 div=1, ch2 div=30, then sync
    do_cfg(3'd1, 16'd1, 1'b1);
    do_cfg(3'd2, 16'(DIV_30), 1'b1);
    @(negedge sys_clk);
    sync_start = 1'b1;
    @(negedge sys_clk);
    sync_start = 1'b0;
    check("sync_wrap", 32'(wrap_cnt), 32'd0);
    check("sync_tick", 32'(tick), 32'd0);
    @(negedge sys_clk);
    check("sync_ch1", 32'(tick[1]), 32'd1);
    wait_tick(2, n);
    check("sync_ch2", 32'(n), 32'd29);
    $display("sync: ch2 ticked %0d cycles after first post-sync edge", n);

    // Held sync keeps every tick low
    sync_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      check("sync_hold", 32'(tick), 32'd0);
    end
    sync_start = 1'b0;
    @(negedge sys_clk);

    // Invalid requests complete the handshake but change nothing
    do_cfg(3'd7, 16'd5, 1'b1);
    check("err_ch7", 32'(cfg_err), 32'd1);
    @(negedge sys_clk);
    check("err_clear", 32'(cfg_err), 32'd0);
    do_cfg(3'd5, 16'd5, 1'b1);
    check("err_ch5", 32'(cfg_err), 32'd1);
    do_cfg(3'd3, 16'd0, 1'b1);
    check("err_div0", 32'(cfg_err), 32'd1);
    @(negedge sys_clk);
    check("err_active", 32'(ch_active), 32'h07);
    do_cfg(3'd4, 16'(DIV_8K), 1'b1);
    check("ok_ch4", 32'(cfg_err), 32'd0);
    do_cfg(3'd4, 16'd0, 1'b0);
    check("ok_dis_div0", 32'(cfg_err), 32'd0);

    // Back to div=4, then disable on the cnt==3 edge
    do_cfg(3'd0, 16'd4, 1'b1);
    wait_tick(0, n);
    wait_tick(0, n);
    check("back_to_4", 32'(n), 32'd4);
    repeat (2) @(negedge sys_clk);
    do_cfg(3'd0, 16'd4, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge sys_clk);
      check("dis_tick0", 32'(tick[0]), 32'd0);
    end
    check("dis_active", 32'(ch_active), 32'h06);

    // Config and sync on the same edge, then re-enable ch0
    do_cfg(3'd3, 16'd7, 1'b1);
    sync_start = 1'b1;
    @(negedge sys_clk);
    sync_start = 1'b0;
    do_cfg(3'd0, 16'd3, 1'b1);
    repeat (40) @(negedge sys_clk);

    // Async reset mid-run
    check("pre_rst_ch1", 32'(tick[1]), 32'd1);
    @(posedge sys_clk);
    #3 reset = 1'b0;
    #1;
    check("arst_tick", 32'(tick), 32'd0);
    check("arst_active", 32'(ch_active), 32'd0);
    check("arst_wrap", 32'(wrap_cnt), 32'd0);
    check("arst_ready", 32'(cfg_ready), 32'd0);
    repeat (2) @(negedge sys_clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      check("post_rst_tick", 32'(tick), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
